// File: rtl/sm_isa_pkg.sv
// Shared ISA definitions for the simple RISC datapath: opcode/op constants,
// loader mnemonic codes, instruction field bit positions and packing helpers.
package sm_isa_pkg;

   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] OP_ZERO  = 2'b00;
   localparam logic [1:0] OP_MOVI  = 2'b10;
   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_CMP   = 2'b01;
   localparam logic [1:0] OP_AND   = 2'b10;
   localparam logic [1:0] OP_MVN   = 2'b11;

   localparam logic [3:0] MN_MOVI  = 4'd0;
   localparam logic [3:0] MN_MOV   = 4'd1;
   localparam logic [3:0] MN_ADD   = 4'd2;
   localparam logic [3:0] MN_CMP   = 4'd3;
   localparam logic [3:0] MN_AND   = 4'd4;
   localparam logic [3:0] MN_MVN   = 4'd5;
   localparam logic [3:0] MN_LDR   = 4'd6;
   localparam logic [3:0] MN_STR   = 4'd7;
   localparam logic [3:0] MN_HALT  = 4'd8;

   localparam int OPC_LSB  = 13;
   localparam int OP_LSB   = 11;
   localparam int RN_LSB   = 8;
   localparam int RD_LSB   = 5;
   localparam int SH_LSB   = 3;
   localparam int RM_LSB   = 0;
   localparam int IMM8_LSB = 0;
   localparam int IMM5_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WRITE,
      ST_DONE
   } loader_state_t;

   // Register-register form: opcode, op, Rn, Rd, shift, Rm.
   function automatic logic [15:0] pack_reg(input logic [2:0] opc, input logic [1:0] op,
                                            input logic [2:0] rn, input logic [2:0] rd,
                                            input logic [1:0] sh, input logic [2:0] rm);
      logic [15:0] w;
      w = '0;
      w[OPC_LSB +: 3] = opc;
      w[OP_LSB  +: 2] = op;
      w[RN_LSB  +: 3] = rn;
      w[RD_LSB  +: 3] = rd;
      w[SH_LSB  +: 2] = sh;
      w[RM_LSB  +: 3] = rm;
      return w;
   endfunction

   // Immediate-move form: opcode, op, Rn, imm8 in the low byte.
   function automatic logic [15:0] pack_imm8(input logic [2:0] opc, input logic [1:0] op,
                                             input logic [2:0] rn, input logic [7:0] imm);
      logic [15:0] w;
      w = '0;
      w[OPC_LSB  +: 3] = opc;
      w[OP_LSB   +: 2] = op;
      w[RN_LSB   +: 3] = rn;
      w[IMM8_LSB +: 8] = imm;
      return w;
   endfunction

   // Load/store form: opcode, op, Rn, Rd, imm5 offset in the low bits.
   function automatic logic [15:0] pack_imm5(input logic [2:0] opc, input logic [1:0] op,
                                             input logic [2:0] rn, input logic [2:0] rd,
                                             input logic [4:0] imm);
      logic [15:0] w;
      w = '0;
      w[OPC_LSB  +: 3] = opc;
      w[OP_LSB   +: 2] = op;
      w[RN_LSB   +: 3] = rn;
      w[RD_LSB   +: 3] = rd;
      w[IMM5_LSB +: 5] = imm;
      return w;
   endfunction

endpackage

// File: rtl/instr_encoder.sv
// Purely combinational field packer: turns a mnemonic plus raw fields into
// the 16-bit machine word, zeroing every field the mnemonic does not use.
module instr_encoder
   import sm_isa_pkg::*;
(
   input  logic [3:0]  mnem,
   input  logic [2:0]  rn,
   input  logic [2:0]  rd,
   input  logic [2:0]  rm,
   input  logic [1:0]  shift,
   input  logic [7:0]  imm8,
   input  logic [4:0]  imm5,
   output logic [15:0] word,
   output logic        legal,
   output logic        is_halt
);

   // Select the encoding form for the mnemonic; codes above HALT are illegal.
   always_comb begin
      word    = '0;
      legal   = 1'b1;
      is_halt = 1'b0;
      case (mnem)
         MN_MOVI: word = pack_imm8(OPC_MOV, OP_MOVI, rn, imm8);
         MN_MOV:  word = pack_reg(OPC_MOV, OP_ZERO, 3'b000, rd, shift, rm);
         MN_ADD:  word = pack_reg(OPC_ALU, OP_ADD, rn, rd, shift, rm);
         MN_CMP:  word = pack_reg(OPC_ALU, OP_CMP, rn, 3'b000, shift, rm);
         MN_AND:  word = pack_reg(OPC_ALU, OP_AND, rn, rd, shift, rm);
         MN_MVN:  word = pack_reg(OPC_ALU, OP_MVN, 3'b000, rd, shift, rm);
         MN_LDR:  word = pack_imm5(OPC_LDR, OP_ZERO, rn, rd, imm5);
         MN_STR:  word = pack_imm5(OPC_STR, OP_ZERO, rn, rd, imm5);
         MN_HALT: begin
            word    = pack_reg(OPC_HALT, OP_ZERO, 3'b000, 3'b000, 2'b00, 3'b000);
            is_halt = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_loader.sv
// Program loader: accepts symbolic instructions, encodes them and writes the
// words to consecutive instruction-memory addresses until HALT or memory full.
module instr_loader
   import sm_isa_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        mnem,
   input  logic [2:0]        rn,
   input  logic [2:0]        rd,
   input  logic [2:0]        rm,
   input  logic [1:0]        shift,
   input  logic [7:0]        imm8,
   input  logic [4:0]        imm5,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_dout,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

   loader_state_t     state, state_next;
   logic [ADDR_W-1:0] addr_next;
   logic [ADDR_W:0]   count_next;
   logic [15:0]       dout_next;
   logic              err_next;
   logic              halt_q, halt_next;

   logic [15:0]       enc_word;
   logic              enc_legal;
   logic              enc_halt;

   instr_encoder u_encoder (
      .mnem    (mnem),
      .rn      (rn),
      .rd      (rd),
      .rm      (rm),
      .shift   (shift),
      .imm8    (imm8),
      .imm5    (imm5),
      .word    (enc_word),
      .legal   (enc_legal),
      .is_halt (enc_halt)
   );

   // State, address, count, word and error registers; reset clears everything at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         mem_addr <= ADDR_BASE;
         count    <= '0;
         mem_dout <= '0;
         err      <= 1'b0;
         halt_q   <= 1'b0;
      end else begin
         state    <= state_next;
         mem_addr <= addr_next;
         count    <= count_next;
         mem_dout <= dout_next;
         err      <= err_next;
         halt_q   <= halt_next;
      end
   end

   // Next-state logic; start overrides whatever the current state decided.
   always_comb begin
      state_next = state;
      addr_next  = mem_addr;
      count_next = count;
      dout_next  = mem_dout;
      err_next   = err;
      halt_next  = halt_q;
      case (state)
         ST_IDLE: ;
         ST_LOAD: begin
            if (in_valid) begin
               if (enc_legal) begin
                  dout_next  = enc_word;
                  halt_next  = enc_halt;
                  state_next = ST_WRITE;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         ST_WRITE: begin
            addr_next  = mem_addr + ADDR_W'(1);
            count_next = count + (ADDR_W+1)'(1);
            if (halt_q) begin
               state_next = ST_DONE;
            end else if (mem_addr == ADDR_LAST) begin
               err_next   = 1'b1;
               state_next = ST_DONE;
            end else begin
               state_next = ST_LOAD;
            end
         end
         ST_DONE: ;
         default: state_next = ST_IDLE;
      endcase
      if (start) begin
         state_next = ST_LOAD;
         addr_next  = ADDR_BASE;
         count_next = '0;
         err_next   = 1'b0;
      end
   end

   assign in_ready  = (state == ST_LOAD);
   assign mem_write = (state == ST_WRITE);
   assign busy      = (state == ST_LOAD) || (state == ST_WRITE);
   assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a default-width instance for the main
// flow and a 2-bit-address instance for the memory-full case.
module tb_instr_loader;
   import sm_isa_pkg::*;

   typedef struct {
      int          addr;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0;
   logic valid_a = 1'b0, valid_b = 1'b0;
   logic [3:0] mnem = '0;
   logic [2:0] rn = '0, rd = '0, rm = '0;
   logic [1:0] shift = '0;
   logic [7:0] imm8 = '0;
   logic [4:0] imm5 = '0;

   logic        ready_a, write_a, busy_a, done_a, err_a;
   logic [7:0]  addr_a;
   logic [15:0] dout_a;
   logic [8:0]  count_a;

   logic        ready_b, write_b, busy_b, done_b, err_b;
   logic [1:0]  addr_b;
   logic [15:0] dout_b;
   logic [2:0]  count_b;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   logic prev_write_a = 1'b0;

   instr_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .in_valid(valid_a), .in_ready(ready_a),
      .mnem(mnem), .rn(rn), .rd(rd), .rm(rm), .shift(shift), .imm8(imm8), .imm5(imm5),
      .mem_write(write_a), .mem_addr(addr_a), .mem_dout(dout_a), .busy(busy_a),
      .done(done_a), .err(err_a), .count(count_a)
   );

   instr_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
      .mnem(mnem), .rn(rn), .rd(rd), .rm(rm), .shift(shift), .imm8(imm8), .imm5(imm5),
      .mem_write(write_b), .mem_addr(addr_b), .mem_dout(dout_b), .busy(busy_b),
      .done(done_b), .err(err_b), .count(count_b)
   );

   always #5 clk = ~clk;

   // Cycle counter used to verify the one-cycle handshake-to-write latency.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Monitor: every write strobe pops one expected item and compares address, data and timing.
   always @(negedge clk) begin
      exp_t e;
      if (write_a) begin
         if (q_a.size() == 0) begin
            checkOutput("A_unexpected_write", 32'(addr_a), 32'hFFFF_FFFF);
         end else begin
            e = q_a.pop_front();
            checkOutput("A_addr", 32'(addr_a), 32'(e.addr));
            checkOutput("A_data", 32'(dout_a), 32'(e.data));
            checkOutput("A_latency", 32'(cyc), 32'(e.cyc));
         end
         if (prev_write_a) checkOutput("A_write_width", 32'(prev_write_a), 32'd0);
      end
      if (write_b) begin
         if (q_b.size() == 0) begin
            checkOutput("B_unexpected_write", 32'(addr_b), 32'hFFFF_FFFF);
         end else begin
            e = q_b.pop_front();
            checkOutput("B_addr", 32'(addr_b), 32'(e.addr));
            checkOutput("B_data", 32'(dout_b), 32'(e.data));
            checkOutput("B_latency", 32'(cyc), 32'(e.cyc));
         end
      end
      prev_write_a <= write_a;
   end

   task automatic startPulse(input bit sel);
      @(negedge clk);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic applyStimulus(input bit sel, input logic [3:0] m,
                                input logic [2:0] f_rn, input logic [2:0] f_rd, input logic [2:0] f_rm,
                                input logic [1:0] f_sh, input logic [7:0] f_i8, input logic [4:0] f_i5,
                                input bit push, input int exp_addr, input logic [15:0] exp_data);
      int n;
      exp_t e;
      @(negedge clk);
      mnem = m; rn = f_rn; rd = f_rd; rm = f_rm; shift = f_sh; imm8 = f_i8; imm5 = f_i5;
      if (sel) valid_b = 1'b1; else valid_a = 1'b1;
      n = 0;
      while (!(sel ? ready_b : ready_a) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checkOutput("handshake_timeout", 32'd0, 32'd1);
         valid_a = 1'b0;
         valid_b = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (push) begin
         e.addr = exp_addr;
         e.data = exp_data;
         e.cyc  = cyc;
         if (sel) q_b.push_back(e); else q_a.push_back(e);
      end
      valid_a = 1'b0;
      valid_b = 1'b0;
      mnem = 4'($urandom); rn = 3'($urandom); rd = 3'($urandom); rm = 3'($urandom);
      shift = 2'($urandom); imm8 = 8'($urandom); imm5 = 5'($urandom);
   endtask

   task automatic waitDone(input bit sel);
      int n;
      n = 0;
      @(negedge clk);
      while (!(sel ? done_b : done_a) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) checkOutput("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      // Reset state
      #2;
      checkOutput("rst_in_ready", 32'(ready_a), 32'd0);
      checkOutput("rst_busy", 32'(busy_a), 32'd0);
      checkOutput("rst_done", 32'(done_a), 32'd0);
      checkOutput("rst_err", 32'(err_a), 32'd0);
      checkOutput("rst_count", 32'(count_a), 32'd0);
      checkOutput("rst_addr", 32'(addr_a), 32'd0);
      checkOutput("rst_dout", 32'(dout_a), 32'd0);
      checkOutput("rst_write", 32'(write_a), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Single MOVI, then restart and load a short program ending in HALT
      startPulse(1'b0);
      checkOutput("start_in_ready", 32'(ready_a), 32'd1);
      applyStimulus(1'b0, MN_MOVI, 3'd0, 3'd5, 3'd6, 2'd3, 8'h07, 5'd9, 1'b1, 0, 16'hD007);
      startPulse(1'b0);
      applyStimulus(1'b0, MN_ADD, 3'd1, 3'd2, 3'd0, 2'b01, 8'hFF, 5'd31, 1'b1, 0, 16'hA148);
      applyStimulus(1'b0, MN_LDR, 3'd2, 3'd3, 3'd7, 2'b11, 8'hAA, 5'd5, 1'b1, 1, 16'h6265);
      applyStimulus(1'b0, MN_HALT, 3'd7, 3'd7, 3'd7, 2'b11, 8'hFF, 5'd31, 1'b1, 2, 16'hE000);
      waitDone(1'b0);
      checkOutput("halt_done", 32'(done_a), 32'd1);
      checkOutput("halt_count", 32'(count_a), 32'd3);
      checkOutput("halt_in_ready", 32'(ready_a), 32'd0);
      checkOutput("halt_err", 32'(err_a), 32'd0);
      checkOutput("halt_busy", 32'(busy_a), 32'd0);

      // Illegal mnemonic is dropped, then every other form is encoded
      startPulse(1'b0);
      applyStimulus(1'b0, 4'hC, 3'd1, 3'd1, 3'd1, 2'd1, 8'h11, 5'd1, 1'b0, 0, 16'h0000);
      checkOutput("ill_err", 32'(err_a), 32'd1);
      checkOutput("ill_in_ready", 32'(ready_a), 32'd1);
      checkOutput("ill_addr", 32'(addr_a), 32'd0);
      checkOutput("ill_write", 32'(write_a), 32'd0);
      applyStimulus(1'b0, MN_MOV, 3'd7, 3'd5, 3'd3, 2'b10, 8'hFF, 5'd31, 1'b1, 0, 16'hC0B3);
      applyStimulus(1'b0, MN_CMP, 3'd7, 3'd6, 3'd1, 2'b11, 8'hFF, 5'd31, 1'b1, 1, 16'hAF19);
      applyStimulus(1'b0, MN_AND, 3'd3, 3'd4, 3'd6, 2'b00, 8'hFF, 5'd31, 1'b1, 2, 16'hB386);
      applyStimulus(1'b0, MN_MVN, 3'd5, 3'd1, 3'd2, 2'b01, 8'hFF, 5'd31, 1'b1, 3, 16'hB82A);
      applyStimulus(1'b0, MN_STR, 3'd5, 3'd6, 3'd7, 2'b11, 8'hFF, 5'd31, 1'b1, 4, 16'h85DF);
      applyStimulus(1'b0, MN_MOVI, 3'd3, 3'd7, 3'd7, 2'b11, 8'hA5, 5'd31, 1'b1, 5, 16'hD3A5);
      applyStimulus(1'b0, MN_HALT, 3'd0, 3'd0, 3'd0, 2'b00, 8'h00, 5'd0, 1'b1, 6, 16'hE000);
      waitDone(1'b0);
      checkOutput("ill_sticky_err", 32'(err_a), 32'd1);
      checkOutput("ill_count", 32'(count_a), 32'd7);

      // start in DONE clears status and reopens LOAD at the base address
      startPulse(1'b0);
      checkOutput("restart_addr", 32'(addr_a), 32'd0);
      checkOutput("restart_count", 32'(count_a), 32'd0);
      checkOutput("restart_err", 32'(err_a), 32'd0);
      checkOutput("restart_in_ready", 32'(ready_a), 32'd1);
      checkOutput("restart_done", 32'(done_a), 32'd0);

      // Reset asserted while a write is strobing
      applyStimulus(1'b0, MN_MOVI, 3'd1, 3'd0, 3'd0, 2'd0, 8'h42, 5'd0, 1'b1, 0, 16'hD142);
      repeat (2) @(negedge clk);
      checkOutput("pre_rst_count", 32'(count_a), 32'd1);
      applyStimulus(1'b0, MN_MOVI, 3'd2, 3'd0, 3'd0, 2'd0, 8'h43, 5'd0, 1'b0, 0, 16'h0000);
      checkOutput("pre_rst_write", 32'(write_a), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("midrst_write", 32'(write_a), 32'd0);
      checkOutput("midrst_busy", 32'(busy_a), 32'd0);
      checkOutput("midrst_count", 32'(count_a), 32'd0);
      checkOutput("midrst_in_ready", 32'(ready_a), 32'd0);
      checkOutput("midrst_done", 32'(done_a), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Two-bit address space fills up without HALT
      startPulse(1'b1);
      applyStimulus(1'b1, MN_MOV, 3'd0, 3'd0, 3'd0, 2'd0, 8'h00, 5'd0, 1'b1, 0, 16'hC000);
      applyStimulus(1'b1, MN_MOV, 3'd0, 3'd1, 3'd1, 2'd0, 8'h00, 5'd0, 1'b1, 1, 16'hC021);
      applyStimulus(1'b1, MN_MOV, 3'd0, 3'd2, 3'd2, 2'd0, 8'h00, 5'd0, 1'b1, 2, 16'hC042);
      applyStimulus(1'b1, MN_MOV, 3'd0, 3'd3, 3'd3, 2'd0, 8'h00, 5'd0, 1'b1, 3, 16'hC063);
      waitDone(1'b1);
      checkOutput("full_done", 32'(done_b), 32'd1);
      checkOutput("full_err", 32'(err_b), 32'd1);
      checkOutput("full_count", 32'(count_b), 32'd4);
      checkOutput("full_addr", 32'(addr_b), 32'd0);
      checkOutput("full_in_ready", 32'(ready_b), 32'd0);

      repeat (3) @(negedge clk);
      checkOutput("A_queue_empty", 32'(q_a.size()), 32'd0);
      checkOutput("B_queue_empty", 32'(q_b.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
# instr_loader

Sequential instruction encoder and program loader for the simple RISC datapath.
- Accepts one symbolic instruction per handshake: a mnemonic plus register, shift and immediate fields.
- Packs the fields into the 16-bit machine word consumed by the instruction decoder.
- Writes the words to consecutive instruction-memory addresses until HALT or memory full.
- Sits between the bench/boot source and instruction memory, so the CPU can be loaded without hand-assembled hex.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory address width
- BASE_ADDR, 0, first write address after start

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; returns every register to its reset value immediately
- start  input  1  single-cycle pulse; begins or restarts a load at BASE_ADDR
- in_valid  input  1  instruction fields valid
- in_ready  output  1  loader can accept fields this cycle
- mnem  input  4  mnemonic code (package constants)
- rn, rd, rm  input  3 each  register fields
- shift  input  2  shifter control
- imm8  input  8  raw immediate for MOVI
- imm5  input  5  raw offset for LDR/STR
- mem_write  output  1  memory write strobe
- mem_addr  output  ADDR_W  write address
- mem_dout  output  16  encoded instruction word
- busy  output  1  high in LOAD or WRITE
- done  output  1  load finished
- err  output  1  sticky error flag, cleared by start
- count  output  ADDR_W+1  words written since start

## Operation
Word layout:
- [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm
- imm8 occupies [7:0]; imm5 occupies [4:0]
- Every field the mnemonic does not use is 0

Encodings:
- MOVI (0): 110,10,rn,imm8
- MOV (1): 110,00,000,rd,shift,rm
- ADD (2): 101,00,rn,rd,shift,rm
- CMP (3): 101,01,rn,000,shift,rm
- AND (4): 101,10,rn,rd,shift,rm
- MVN (5): 101,11,000,rd,shift,rm
- LDR (6): 011,00,rn,rd,imm5
- STR (7): 100,00,rn,rd,imm5
- HALT (8): 111,00, rest 0
- Codes 9–15 are illegal

State machine:
- IDLE: wait for start.
- LOAD: in_ready=1. On in_valid&in_ready:
  - Legal mnemonic: register the encoded word and the is-HALT flag, go to WRITE.
  - Illegal mnemonic: set err, drop the word, stay in LOAD, leave mem_addr unchanged.
- WRITE: mem_write=1 for exactly one cycle with the registered mem_addr/mem_dout. At the cycle end:
  - mem_addr increments modulo 2^ADDR_W; count increments.
  - If the word was HALT, go to DONE.
  - Else if mem_addr was 2^ADDR_W−1, set err (memory full, unterminated program) and go to DONE.
  - Otherwise return to LOAD.
- DONE: done=1, in_ready=0; hold until start.

start behaviour:
- Honoured in every state; next state is LOAD, mem_addr=BASE_ADDR, count=0, err=0, done=0.
- A write already strobing in WRITE still completes that cycle.

## Timing
- Reset values (asynchronous): state IDLE, mem_write 0, mem_addr BASE_ADDR, mem_dout 0, in_ready 0, busy 0, done 0, err 0, count 0.
- All outputs are Moore/registered; no combinational path from input to output.
- Latency: fields accepted at edge N produce mem_write high during cycle N+1, with stable addr/data.
- Throughput: one instruction per two cycles; in_ready is 0 during WRITE.
- mem_addr and count update at the edge ending WRITE.
- done rises in the cycle after the final write.
- in_valid without in_ready is ignored; fields need not be held.
- Reset asserted mid-WRITE drops mem_write in the same cycle.

## Structure
- Shared package sm_isa_pkg holds:
  - the opcode and op constants (used by the decoder too)
  - the mnemonic codes MN_MOVI..MN_HALT
  - the field bit positions
- Sub-module instr_encoder: purely combinational field packer (mnem + fields → word + legal flag).
- instr_loader holds the FSM, address/count registers and output registers.

## Test plan
- start; MOVI rn=0 imm8=8'h07 → one mem_write at addr 0, mem_dout=16'hD007, one cycle after handshake.
- ADD rn=1 rd=2 shift=01 rm=0, then LDR rn=2 rd=3 imm5=5, then HALT → words A148, 6265, E000 at addrs 0,1,2; then done=1, count=3, in_ready=0, err=0.
- Illegal mnem=4'hC in LOAD → err=1, no mem_write, mem_addr unchanged, in_ready stays 1; the next legal word is written at the same address.
- ADDR_W=2: four MOV words with no HALT → writes at 0..3, then done=1, err=1, count=4, mem_addr=0.
- Reset pulsed while mem_write=1 → mem_write, busy and count go to 0 immediately; state IDLE.
- start pulsed in DONE → mem_addr=BASE_ADDR, count=0, err=0, in_ready=1 on the next cycle.
